// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard unit: load-use stall sequencing, branch/jump squash,
// and saturating stall/flush performance counters.
module hazard_stall_controller #(
   parameter int LOAD_USE_STALL = 1,
   parameter int FLUSH_CYCLES   = 1,
   parameter int CNT_W          = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             ID_Jump,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_Rd,
   input  logic             BranchTaken_EX,
   input  logic             ClrCnt,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Bubble,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [2:0]       STALL_RELOAD = 3'(LOAD_USE_STALL - 1);
   localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   generate
      if (LOAD_USE_STALL < 1 || LOAD_USE_STALL > 7) begin : g_bad_stall
         $error("hazard_stall_controller: LOAD_USE_STALL must be 1..7");
      end
      if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush
         $error("hazard_stall_controller: FLUSH_CYCLES must be 1..3");
      end
      if (CNT_W < 1) begin : g_bad_cnt
         $error("hazard_stall_controller: CNT_W must be at least 1");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             hazard;

   // Register 0 is hardwired to zero, so a load targeting it never blocks a reader.
   assign hazard = EX_MemRead && (EX_Rd != 5'd0) &&
                   ((ID_UsesRs && (EX_Rd == ID_Rs)) ||
                    (ID_UsesRt && (EX_Rd == ID_Rt)));

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_d     = ST_RUN;
      cnt_d       = 3'd0;
      PCWrite     = 1'b1;
      IFID_Write  = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;

      if (BranchTaken_EX) begin
         // A taken branch wins in every state, including a reload inside FLUSH.
         IFID_Flush  = 1'b1;
         IDEX_Bubble = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
         end
      end else begin
         case (state_q)
            ST_STALL: begin
               PCWrite     = 1'b0;
               IFID_Write  = 1'b0;
               IDEX_Bubble = 1'b1;
               if (cnt_q != 3'd1) begin
                  state_d = ST_STALL;
                  cnt_d   = cnt_q - 3'd1;
               end
            end
            ST_FLUSH: begin
               IFID_Flush  = 1'b1;
               IDEX_Bubble = 1'b1;
               if (cnt_q != 3'd1) begin
                  state_d = ST_FLUSH;
                  cnt_d   = cnt_q - 3'd1;
               end
            end
            default: begin
               if (hazard) begin
                  PCWrite     = 1'b0;
                  IFID_Write  = 1'b0;
                  IDEX_Bubble = 1'b1;
                  if (LOAD_USE_STALL > 1) begin
                     state_d = ST_STALL;
                     cnt_d   = STALL_RELOAD;
                  end
               end else if (ID_Jump) begin
                  IFID_Flush = 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (ClrCnt) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (IDEX_Bubble && !IFID_Flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
         end
         if (IFID_Flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!Rst) begin
         state_q     <= ST_RUN;
         cnt_q       <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule
